// File: rtl/reg_write_ctrl.sv
// reg_write_ctrl: registered one-hot register-file write select plus a
// per-register pending-write scoreboard that drives issue stall and err.
module reg_write_ctrl #(
   parameter int NREG = 16,
   parameter int AW   = 4,
   parameter int CW   = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            LE,
   input  logic [AW-1:0]   RW,
   input  logic            iss_en,
   input  logic [AW-1:0]   iss_rd,
   input  logic [AW-1:0]   rs_a,
   input  logic [AW-1:0]   rs_b,
   output logic [NREG-1:0] regnum,
   output logic [NREG-1:0] busy,
   output logic            stall,
   output logic            err
);

   localparam logic [CW-1:0] PEND_MAX = '1;

   logic [CW-1:0]   pend_q [NREG];
   logic [CW-1:0]   pend_d [NREG];
   logic [NREG-1:0] regnum_q;
   logic [NREG-1:0] regnum_d;
   logic            err_q;
   logic            err_d;

   logic [NREG-1:0] inc_sel;
   logic [NREG-1:0] dec_sel;
   logic            rd_full;
   logic            iss_ok;
   logic            wb_ok;
   logic            wb_under;

   function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
      return NREG'(1) << a;
   endfunction

   // busy flags come straight from the registered counters
   always_comb begin
      busy = '0;
      for (int i = 0; i < NREG; i++) begin
         busy[i] = (pend_q[i] != '0);
      end
   end

   // issue hazard: a source still pending, or the destination counter full
   always_comb begin
      rd_full = (pend_q[iss_rd] == PEND_MAX);
      stall   = busy[rs_a] | busy[rs_b] | rd_full;
   end

   // qualify issue and writeback, select which counters move
   always_comb begin
      iss_ok   = iss_en & ~stall;
      wb_ok    = LE & busy[RW];
      wb_under = LE & ~busy[RW];
      inc_sel  = iss_ok ? onehot(iss_rd) : '0;
      dec_sel  = wb_ok ? onehot(RW) : '0;
   end

   // counter next state; matching inc and dec on one register cancel
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         pend_d[i] = pend_q[i];
         unique case ({inc_sel[i], dec_sel[i]})
            2'b10:   pend_d[i] = pend_q[i] + CW'(1);
            2'b01:   pend_d[i] = pend_q[i] - CW'(1);
            default: pend_d[i] = pend_q[i];
         endcase
      end
   end

   // write select and sticky underflow next state
   always_comb begin
      regnum_d = LE ? onehot(RW) : '0;
      err_d    = err_q | wb_under;
   end

   // state registers; reset discards any same-cycle issue or writeback
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            pend_q[i] <= '0;
         end
         regnum_q <= '0;
         err_q    <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            pend_q[i] <= pend_d[i];
         end
         regnum_q <= regnum_d;
         err_q    <= err_d;
      end
   end

   assign regnum = regnum_q;
   assign err    = err_q;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// tb_reg_write_ctrl: directed vector table, hand sequences and randomized
// run against a counter-array reference model of the scoreboard.
module tb_reg_write_ctrl;

   localparam int MAXP = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        LE;
   logic [3:0]  RW;
   logic        iss_en;
   logic [3:0]  iss_rd;
   logic [3:0]  rs_a;
   logic [3:0]  rs_b;
   logic [15:0] regnum;
   logic [15:0] busy;
   logic        stall;
   logic        err;

   logic        le32;
   logic [4:0]  rw32;
   logic        iss_en32;
   logic [4:0]  iss_rd32;
   logic [4:0]  rs_a32;
   logic [4:0]  rs_b32;
   logic [31:0] regnum32;
   logic [31:0] busy32;
   logic        stall32;
   logic        err32;

   int checks = 0;
   int failures = 0;

   reg_write_ctrl #(.NREG(16), .AW(4), .CW(2)) dut (
      .clk(clk), .reset(reset), .LE(LE), .RW(RW),
      .iss_en(iss_en), .iss_rd(iss_rd), .rs_a(rs_a), .rs_b(rs_b),
      .regnum(regnum), .busy(busy), .stall(stall), .err(err)
   );

   reg_write_ctrl #(.NREG(32), .AW(5), .CW(2)) dut32 (
      .clk(clk), .reset(reset), .LE(le32), .RW(rw32),
      .iss_en(iss_en32), .iss_rd(iss_rd32), .rs_a(rs_a32), .rs_b(rs_b32),
      .regnum(regnum32), .busy(busy32), .stall(stall32), .err(err32)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   typedef struct {
      bit          rst;
      bit          le;
      logic [3:0]  rw;
      bit          ie;
      logic [3:0]  ird;
      logic [3:0]  ra;
      logic [3:0]  rb;
      bit          stall;
      logic [15:0] regnum;
      logic [15:0] busy;
      bit          err;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(bit rst, bit le, int rw, bit ie, int ird,
                               int ra, int rb, bit st, int rn, int bz,
                               bit er);
      vec_t t;
      t.rst = rst; t.le = le; t.rw = 4'(rw); t.ie = ie;
      t.ird = 4'(ird); t.ra = 4'(ra); t.rb = 4'(rb);
      t.stall = st; t.regnum = 16'(rn); t.busy = 16'(bz); t.err = er;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit rst, input bit le, input logic [3:0] rw,
                        input bit ie, input logic [3:0] ird,
                        input logic [3:0] ra, input logic [3:0] rb);
      reset = rst; LE = le; RW = rw; iss_en = ie;
      iss_rd = ird; rs_a = ra; rs_b = rb;
   endtask

   // ---------------- reference model ----------------
   int          pend_m [16];
   logic [15:0] regnum_m;
   bit          err_m;

   function automatic logic [15:0] busy_of_model();
      logic [15:0] b;
      b = '0;
      for (int i = 0; i < 16; i++) b[i] = (pend_m[i] > 0);
      return b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) pend_m[i] = 0;
      regnum_m = '0;
      err_m = 0;
   endtask

   task automatic rand_step(input int n);
      bit rst, le, ie, st_m, dec;
      int rw, ird, ra, rb;
      logic [15:0] one;
      rst = ($urandom_range(0, 63) == 0);
      le  = ($urandom_range(0, 9) < 4);
      ie  = ($urandom_range(0, 9) < 6);
      rw  = $urandom_range(0, 5);
      ird = $urandom_range(0, 5);
      ra  = $urandom_range(0, 15);
      rb  = $urandom_range(0, 15);
      drive(rst, le, 4'(rw), ie, 4'(ird), 4'(ra), 4'(rb));
      #1;
      st_m = (pend_m[ra] > 0) || (pend_m[rb] > 0) || (pend_m[ird] == MAXP);
      chk($sformatf("rnd%0d.stall", n), 64'(stall), 64'(st_m));
      if (rst) begin
         model_reset();
      end else begin
         one = 16'h0001;
         regnum_m = le ? (one << rw) : 16'h0000;
         dec = le && (pend_m[rw] > 0);
         if (le && !dec) err_m = 1;
         if (dec) pend_m[rw] = pend_m[rw] - 1;
         if (ie && !st_m) pend_m[ird] = pend_m[ird] + 1;
      end
      @(posedge clk); #1;
      chk($sformatf("rnd%0d.regnum", n), 64'(regnum), 64'(regnum_m));
      chk($sformatf("rnd%0d.busy", n), 64'(busy), 64'(busy_of_model()));
      chk($sformatf("rnd%0d.err", n), 64'(err), 64'(err_m));
      chk($sformatf("rnd%0d.onehot", n), 64'($countones(regnum) <= 1), 64'(1));
   endtask

   task automatic apply(input vec_t t, input int n);
      drive(t.rst, t.le, t.rw, t.ie, t.ird, t.ra, t.rb);
      #1;
      chk($sformatf("vec%0d.stall", n), 64'(stall), 64'(t.stall));
      @(posedge clk); #1;
      chk($sformatf("vec%0d.regnum", n), 64'(regnum), 64'(t.regnum));
      chk($sformatf("vec%0d.busy", n), 64'(busy), 64'(t.busy));
      chk($sformatf("vec%0d.err", n), 64'(err), 64'(t.err));
   endtask

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0);
      le32 = 0; rw32 = '0; iss_en32 = 0;
      iss_rd32 = '0; rs_a32 = '0; rs_b32 = '0;

      // decode sweep (LE with nothing pending also underflows)
      for (int i = 0; i < 16; i++)
         vq.push_back(mk(0, 1, i, 0, 0, 0, 0, 0, 1 << i, 0, 1));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      // reset beats simultaneous LE/iss_en
      vq.push_back(mk(1, 1, 3, 1, 2, 0, 0, 0, 0, 0, 0));
      // hazard on rs_a
      vq.push_back(mk(0, 0, 0, 1, 5, 0, 0, 0, 0, 'h20, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 5, 0, 1, 0, 'h20, 0));
      vq.push_back(mk(0, 1, 5, 0, 0, 5, 0, 1, 'h20, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0));
      // full counter on r3
      for (int i = 0; i < 3; i++)
         vq.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0, 0, 8, 0));
      vq.push_back(mk(0, 0, 0, 1, 3, 0, 0, 1, 0, 8, 0));
      vq.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 8, 8, 0));
      vq.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 8, 8, 0));
      vq.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 8, 0, 0));
      // simultaneous issue and writeback
      vq.push_back(mk(0, 0, 0, 1, 7, 0, 0, 0, 0, 'h80, 0));
      vq.push_back(mk(0, 1, 7, 1, 7, 0, 0, 0, 'h80, 'h80, 0));
      vq.push_back(mk(0, 1, 7, 1, 2, 0, 0, 0, 'h80, 'h04, 0));
      vq.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 'h04, 0, 0));
      // underflow, sticky err
      vq.push_back(mk(0, 1, 9, 0, 0, 0, 0, 0, 'h200, 0, 1));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      vq.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 2, 1));
      // reset mid-operation with pend[1]=2, pend[4]=1
      vq.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 2, 1));
      vq.push_back(mk(0, 0, 0, 1, 4, 0, 0, 0, 0, 'h12, 1));
      vq.push_back(mk(1, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0));
      // hazard on rs_b, blocked issue ignored
      vq.push_back(mk(0, 0, 0, 1, 10, 0, 0, 0, 0, 'h400, 0));
      vq.push_back(mk(0, 0, 0, 1, 11, 0, 10, 1, 0, 'h400, 0));
      vq.push_back(mk(0, 1, 10, 0, 0, 0, 0, 0, 'h400, 0, 0));
      // register 0 is an ordinary register
      vq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      vq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0));

      // reset state
      @(posedge clk); @(posedge clk); #1;
      chk("rst.regnum", 64'(regnum), 64'(0));
      chk("rst.busy", 64'(busy), 64'(0));
      chk("rst.err", 64'(err), 64'(0));
      drive(1, 0, 0, 0, 15, 3, 9);
      #1;
      chk("rst.stall", 64'(stall), 64'(0));
      chk("rst.busy32", 64'(busy32), 64'(0));
      chk("rst.stall32", 64'(stall32), 64'(0));
      reset = 0;

      foreach (vq[i]) apply(vq[i], i);

      // wide instance: top register decodes to bit 31
      drive(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 0;
      le32 = 1; rw32 = 5'd31;
      @(posedge clk); #1;
      chk("p32.regnum31", 64'(regnum32), 64'h8000_0000);
      rw32 = 5'd16;
      @(posedge clk); #1;
      chk("p32.regnum16", 64'(regnum32), 64'h0001_0000);
      chk("p32.err", 64'(err32), 64'(1));
      le32 = 0;
      @(posedge clk); #1;
      chk("p32.idle", 64'(regnum32), 64'(0));

      // randomized run against the model
      drive(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      model_reset();
      for (int n = 0; n < 600; n++) rand_step(n);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
